naval_board_ctrl: RTL
=====================

Name: naval_board_ctrl

Overview:
- Parametrised battleship board controller: holds a ROWS x COLS ship map and a matching attack map.
- Resolves one shot per fire pulse through a small FSM and keeps hit and shot counters.
- Flags game over when every ship cell has been hit.
- Drives a column-scanned LED matrix in four display modes. Sits between the switch/button debouncers and the LED matrix and 7-segment drivers; replaces the fixed 5x7 register-plus-mux arrangement.

Parameters:
- ROWS, 7, matrix lines (1..8).
- COLS, 5, matrix columns (1..8).
- COORD_W, 3, width of row/col coordinate inputs; must hold max(ROWS,COLS)-1.
- BLINK_DIV, 4, number of full scan frames per blink-phase toggle (>=1).
- CNT_W, derived clog2(ROWS*COLS+1), width of the counters.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-low reset.
- load  in  1  one-cycle pulse: start a new game from preset.
- preset  in  ROWS*COLS  ship layout; bit r*COLS+c = cell (row r, col c), row 0 is the top.
- fire  in  1  one-cycle pulse: shoot at (row,col).
- row  in  COORD_W  target row.
- col  in  COORD_W  target column.
- scan_tick  in  1  enable: advance the display column.
- disp_mode  in  2  0 ships, 1 all attacks, 2 hits only, 3 ships with hit cells blinking.
- m_col  out  COLS  one-hot active-high column select.
- m_line  out  ROWS  line data for the selected column; bit r = row r.
- status  out  3  last result: 0 NONE, 1 MISS, 2 HIT, 3 REPEAT, 4 INVALID.
- result_valid  out  1  one-cycle strobe when status is updated.
- busy  out  1  high in EVAL.
- game_over  out  1  high in OVER.
- hits_cnt  out  CNT_W  distinct ship cells hit.
- shots_cnt  out  CNT_W  accepted shots (MISS or HIT only).

Behaviour:
- All state changes at rising clk. clr=0 has top priority.
- Reset clears ship_map, attack_map, ship_total, both counters, col_idx and blink phase. State goes to IDLE. Every output is 0, including m_col, m_line and status=NONE.
- FSM states: IDLE, EVAL, OVER.
- load=1 (clr=1), from any state, has priority over fire:
  - ship_map <= preset; attack_map <= 0; counters <= 0; status <= NONE; no result_valid.
  - ship_total <= popcount(preset); state <= IDLE.
  - An empty preset gives IDLE with game_over=0, and HIT can never occur.
- IDLE, fire=1: latch row/col, state <= EVAL, busy=1 the following cycle.
- EVAL: exactly one cycle, at the next edge:
  - row>=ROWS or col>=COLS -> INVALID, no map or counter change.
  - attack bit already set -> REPEAT, no change.
  - otherwise set the attack bit and increment shots_cnt; ship bit set -> HIT and hits_cnt+1; else MISS.
  - result_valid=1 for that one cycle. Latency: fire at edge N -> status valid after edge N+1.
  - If the new hits_cnt equals ship_total (and ship_total>0), state <= OVER; else IDLE.
- fire in EVAL or OVER is ignored, with no status change. fire must be re-issued after busy drops.
- OVER: game_over=1, held until load or clr. status keeps its last value (HIT).
- Counters cannot overflow: shots_cnt <= ROWS*COLS by construction.
- Scan:
  - On scan_tick, col_idx increments and wraps at COLS-1 -> 0.
  - Each wrap from COLS-1 to 0 counts one frame. After BLINK_DIV frames, blink phase toggles and the frame count clears.
- m_col/m_line are registered and updated every cycle from the current col_idx, so they lag col_idx by one cycle and are always mutually consistent.
- m_line[r] by disp_mode:
  - 0: ship(r,c).
  - 1: attack(r,c).
  - 2: ship & attack.
  - 3: ship & ~(attack & blink).
- load/fire in the same cycle as scan_tick: both take effect; display reflects the new maps one cycle later.
- clr mid-EVAL aborts the shot with no result_valid.

Test Plan:
- Reset then load preset with cells (0,0),(2,4) set (ROWS=7,COLS=5) -> status 0, hits 0, shots 0, game_over 0; disp_mode 0 with col 0 -> m_col=00001, m_line bit0=1.
- Fire (1,1) -> busy next cycle, result_valid one cycle later with status=MISS, shots=1, hits=0; fire (1,1) again -> REPEAT, shots stays 1.
- Fire (7,0) and (0,5) -> INVALID both, counters unchanged; fire asserted while busy -> ignored, exactly one result_valid.
- Fire (0,0) then (2,4) -> HIT, HIT, hits=2, shots=3, game_over=1; further fire -> no result_valid; load -> game_over 0, counters 0.
- disp_mode 3 with hit at (0,0), BLINK_DIV=1, scan_tick every cycle -> (0,0) LED toggles every 5 ticks; m_col sequence 00001..10000 wraps to 00001.
- clr=0 asserted during EVAL -> all outputs 0 next cycle, no result_valid; load and fire in the same cycle -> load wins, shots=0.

Source files
------------

// File: rtl/naval_board_ctrl_if.sv
// naval_board_ctrl_if: bundles the game control, shot result and LED matrix
// signals of the battleship board controller.
interface naval_board_ctrl_if #(
  parameter int ROWS    = 7,
  parameter int COLS    = 5,
  parameter int COORD_W = 3
);
  localparam int CNT_W = $clog2(ROWS * COLS + 1);

  logic                 load;
  logic [ROWS*COLS-1:0] preset;
  logic                 fire;
  logic [COORD_W-1:0]   row;
  logic [COORD_W-1:0]   col;
  logic                 scan_tick;
  logic [1:0]           disp_mode;
  logic [COLS-1:0]      m_col;
  logic [ROWS-1:0]      m_line;
  logic [2:0]           status;
  logic                 result_valid;
  logic                 busy;
  logic                 game_over;
  logic [CNT_W-1:0]     hits_cnt;
  logic [CNT_W-1:0]     shots_cnt;

  modport master (
    output load, preset, fire, row, col, scan_tick, disp_mode,
    input  m_col, m_line, status, result_valid, busy, game_over, hits_cnt, shots_cnt
  );

  modport slave (
    input  load, preset, fire, row, col, scan_tick, disp_mode,
    output m_col, m_line, status, result_valid, busy, game_over, hits_cnt, shots_cnt
  );
endinterface

// File: rtl/naval_board_ctrl.sv
// naval_board_ctrl: battleship board with ship/attack maps, a one-shot-at-a-time
// resolver FSM, hit/shot counters and a column-scanned LED matrix output.
module naval_board_ctrl #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int COORD_W   = 3,
  parameter int BLINK_DIV = 4
) (
  input logic              clk,
  input logic              clr,
  naval_board_ctrl_if.slave bus
);
  localparam int CELLS  = ROWS * COLS;
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_MISS    = 3'd1;
  localparam logic [2:0] ST_HIT     = 3'd2;
  localparam logic [2:0] ST_REPEAT  = 3'd3;
  localparam logic [2:0] ST_INVALID = 3'd4;

  localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(COLS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(BLINK_DIV - 1);

  logic [1:0]         state;
  logic [CELLS-1:0]   ship_map;
  logic [CELLS-1:0]   attack_map;
  logic [CNT_W-1:0]   ship_total;
  logic [CNT_W-1:0]   hits;
  logic [CNT_W-1:0]   shots;
  logic [2:0]         status;
  logic               result_valid;
  logic [COORD_W-1:0] row_q;
  logic [COORD_W-1:0] col_q;
  logic [CIDX_W-1:0]  col_idx;
  logic [FRM_W-1:0]   frame_cnt;
  logic               blink;
  logic [COLS-1:0]    m_col;
  logic [ROWS-1:0]    m_line;

  logic [CELLS-1:0]   cell_sel;
  logic               cell_valid;
  logic               cell_ship;
  logic               cell_attacked;
  logic [CNT_W-1:0]   hits_inc;
  logic [CNT_W-1:0]   preset_pop;
  logic [ROWS-1:0]    ship_col;
  logic [ROWS-1:0]    attack_col;
  logic [COLS-1:0]    col_onehot;

  // Decode the latched target into a one-hot cell select; out-of-range targets select nothing.
  always_comb begin
    cell_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cell_sel[r*COLS+c] = (row_q == COORD_W'(r)) && (col_q == COORD_W'(c));
      end
    end
    cell_valid    = |cell_sel;
    cell_ship     = |(cell_sel & ship_map);
    cell_attacked = |(cell_sel & attack_map);
    hits_inc      = hits + CNT_W'(1);
  end

  // Count ship cells in the incoming layout so game over can be detected later.
  always_comb begin
    preset_pop = '0;
    for (int i = 0; i < CELLS; i++) begin
      preset_pop = preset_pop + CNT_W'(bus.preset[i]);
    end
  end

  // Extract the currently scanned column from both maps.
  always_comb begin
    ship_col   = '0;
    attack_col = '0;
    col_onehot = '0;
    for (int c = 0; c < COLS; c++) begin
      col_onehot[c] = (col_idx == CIDX_W'(c));
      for (int r = 0; r < ROWS; r++) begin
        if (col_idx == CIDX_W'(c)) begin
          ship_col[r]   = ship_map[r*COLS+c];
          attack_col[r] = attack_map[r*COLS+c];
        end
      end
    end
  end

  // Game FSM: load restarts from any state, fire is only taken in IDLE, EVAL resolves in one cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state        <= S_IDLE;
      ship_map     <= '0;
      attack_map   <= '0;
      ship_total   <= '0;
      hits         <= '0;
      shots        <= '0;
      status       <= ST_NONE;
      result_valid <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
    end else if (bus.load) begin
      state        <= S_IDLE;
      ship_map     <= bus.preset;
      attack_map   <= '0;
      ship_total   <= preset_pop;
      hits         <= '0;
      shots        <= '0;
      status       <= ST_NONE;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.fire) begin
            row_q <= bus.row;
            col_q <= bus.col;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          result_valid <= 1'b1;
          state        <= S_IDLE;
          if (!cell_valid) begin
            status <= ST_INVALID;
          end else if (cell_attacked) begin
            status <= ST_REPEAT;
          end else begin
            attack_map <= attack_map | cell_sel;
            shots      <= shots + CNT_W'(1);
            if (cell_ship) begin
              status <= ST_HIT;
              hits   <= hits_inc;
              if (hits_inc == ship_total) begin
                state <= S_OVER;
              end
            end else begin
              status <= ST_MISS;
            end
          end
        end
        S_OVER: begin
          state <= S_OVER;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Column scanner with frame counting that drives the blink phase.
  always_ff @(posedge clk) begin
    if (!clr) begin
      col_idx   <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (bus.scan_tick) begin
      if (col_idx == COL_LAST) begin
        col_idx <= '0;
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end else begin
        col_idx <= col_idx + CIDX_W'(1);
      end
    end
  end

  // Register column select and line data together so the matrix never sees a torn pair.
  always_ff @(posedge clk) begin
    if (!clr) begin
      m_col  <= '0;
      m_line <= '0;
    end else begin
      m_col <= col_onehot;
      case (bus.disp_mode)
        2'd0:    m_line <= ship_col;
        2'd1:    m_line <= attack_col;
        2'd2:    m_line <= ship_col & attack_col;
        default: m_line <= ship_col & ~(attack_col & {ROWS{blink}});
      endcase
    end
  end

  assign bus.m_col        = m_col;
  assign bus.m_line       = m_line;
  assign bus.status       = status;
  assign bus.result_valid = result_valid;
  assign bus.busy         = (state == S_EVAL);
  assign bus.game_over    = (state == S_OVER);
  assign bus.hits_cnt     = hits;
  assign bus.shots_cnt    = shots;
endmodule
